// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the exec_decode_unit slice.
//   - opcode / func field values of the supported MIPS subset
//   - alu_class codes (main decoder -> function decoder)
//   - alu_sel codes (function decoder -> ALU)
//   - reg_dst / mem_to_reg mux encodings
//   - decodeFunc(): R-type func field -> alu_sel
// Configuration macro: EXEC_SHIFT_EN (enables SLLV/SRLV/SRAV decode).
package exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] CLS_ADD   = 3'b000;
  localparam logic [2:0] CLS_SUB   = 3'b001;
  localparam logic [2:0] CLS_RTYPE = 3'b010;
  localparam logic [2:0] CLS_AND   = 3'b011;
  localparam logic [2:0] CLS_OR    = 3'b100;
  localparam logic [2:0] CLS_XOR   = 3'b101;
  localparam logic [2:0] CLS_SLT   = 3'b110;
  localparam logic [2:0] CLS_LUI   = 3'b111;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLLV = 5'd8;
  localparam logic [4:0] ALU_SRLV = 5'd9;
  localparam logic [4:0] ALU_SRAV = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_ZERO = 5'd31;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  function automatic logic [4:0] decodeFunc(input logic [5:0] fn);
    logic [4:0] sel;
    sel = ALU_ZERO;
    case (fn)
      FN_ADD, FN_ADDU: sel = ALU_ADD;
      FN_SUB, FN_SUBU: sel = ALU_SUB;
      FN_AND:          sel = ALU_AND;
      FN_OR:           sel = ALU_OR;
      FN_XOR:          sel = ALU_XOR;
      FN_NOR:          sel = ALU_NOR;
      FN_SLT:          sel = ALU_SLT;
      FN_SLTU:         sel = ALU_SLTU;
`ifdef EXEC_SHIFT_EN
      FN_SLLV:         sel = ALU_SLLV;
      FN_SRLV:         sel = ALU_SRLV;
      FN_SRAV:         sel = ALU_SRAV;
`endif
      default:         sel = ALU_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/exec_decode_unit_alu_core.sv
// alu_core: combinational 32-bit ALU.
// Ports:
//   a       in  32  source 1 (also the shift amount in a[4:0])
//   b       in  32  source 2 (shifted operand / LUI immediate)
//   aluSel  in   5  operation code from exec_pkg
//   result  out 32  ALU result
//   zero    out  1  result == 0
// Configuration macro: EXEC_SHIFT_EN (variable shifts present only when defined).
module alu_core
  import exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  aluSel,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'h0;
    case (aluSel)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'h0, a < b};
`ifdef EXEC_SHIFT_EN
      ALU_SLLV: result = b << a[4:0];
      ALU_SRLV: result = b >> a[4:0];
      ALU_SRAV: result = $unsigned($signed(b) >>> a[4:0]);
`endif
      ALU_LUI:  result = {b[15:0], 16'h0};
      default:  result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/exec_decode_unit.sv
// exec_decode_unit: main-control decoder, ALU-function decoder and ALU for the
// single-cycle MIPS datapath, followed by one output register stage.
// Ports:
//   clk, rst (async active-high)       clock / reset
//   in_valid, opcode, func, a, b       instruction fields and selected operands
//   out_valid                          registered in_valid
//   reg_dst, branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg,
//   alu_class, imm_ext_sign, alu_sel   registered control decode
//   alu_out, zero                      registered ALU result and zero flag
// Configuration macro: EXEC_SHIFT_EN (SLLV/SRLV/SRAV support).
module exec_decode_unit
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [1:0]  reg_dst,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic [2:0]  alu_class,
  output logic        imm_ext_sign,
  output logic [4:0]  alu_sel,
  output logic [31:0] alu_out,
  output logic        zero
);

  logic [1:0]  regDstN;
  logic        branchN, memReadN, memWriteN, aluSrcN, regWriteN, signN;
  logic [1:0]  memToRegN;
  logic [2:0]  classN;
  logic [4:0]  selN;
  logic [31:0] aluResult;
  logic        aluZero;

  // Main control decode; unlisted opcodes (including j) leave everything 0.
  always_comb begin
    regDstN   = REGDST_RT;
    branchN   = 1'b0;
    memReadN  = 1'b0;
    memWriteN = 1'b0;
    aluSrcN   = 1'b0;
    regWriteN = 1'b0;
    memToRegN = WB_ALU;
    classN    = CLS_ADD;
    signN     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regDstN   = REGDST_RD;
        regWriteN = 1'b1;
        classN    = CLS_RTYPE;
      end
      OP_LW: begin
        aluSrcN   = 1'b1;
        memReadN  = 1'b1;
        memToRegN = WB_MEM;
        regWriteN = 1'b1;
        signN     = 1'b1;
      end
      OP_SW: begin
        aluSrcN   = 1'b1;
        memWriteN = 1'b1;
        signN     = 1'b1;
      end
      OP_BEQ: begin
        branchN = 1'b1;
        signN   = 1'b1;
        classN  = CLS_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        signN     = 1'b1;
      end
      OP_SLTI: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        signN     = 1'b1;
        classN    = CLS_SLT;
      end
      OP_ANDI: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        classN    = CLS_AND;
      end
      OP_ORI: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        classN    = CLS_OR;
      end
      OP_XORI: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        classN    = CLS_XOR;
      end
      OP_LUI: begin
        aluSrcN   = 1'b1;
        regWriteN = 1'b1;
        classN    = CLS_LUI;
      end
      OP_JAL: begin
        regDstN   = REGDST_R31;
        memToRegN = WB_PC4;
        regWriteN = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    selN = ALU_ADD;
    case (classN)
      CLS_ADD:   selN = ALU_ADD;
      CLS_SUB:   selN = ALU_SUB;
      CLS_RTYPE: selN = decodeFunc(func);
      CLS_AND:   selN = ALU_AND;
      CLS_OR:    selN = ALU_OR;
      CLS_XOR:   selN = ALU_XOR;
      CLS_SLT:   selN = ALU_SLT;
      CLS_LUI:   selN = ALU_LUI;
      default:   selN = ALU_ZERO;
    endcase
  end

  alu_core uAlu (
    .a      (a),
    .b      (b),
    .aluSel (selN),
    .result (aluResult),
    .zero   (aluZero)
  );

  // out_valid follows in_valid every cycle; the payload only loads on a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      reg_dst      <= 2'd0;
      branch       <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      alu_src      <= 1'b0;
      reg_write    <= 1'b0;
      mem_to_reg   <= 2'd0;
      alu_class    <= 3'd0;
      imm_ext_sign <= 1'b0;
      alu_sel      <= 5'd0;
      alu_out      <= 32'h0;
      zero         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        reg_dst      <= regDstN;
        branch       <= branchN;
        mem_read     <= memReadN;
        mem_write    <= memWriteN;
        alu_src      <= aluSrcN;
        reg_write    <= regWriteN;
        mem_to_reg   <= memToRegN;
        alu_class    <= classN;
        imm_ext_sign <= signN;
        alu_sel      <= selN;
        alu_out      <= aluResult;
        zero         <= aluZero;
      end
    end
  end

endmodule

// File: tb/tb_exec_decode_unit.sv
// Directed bench for exec_decode_unit; expected values are hand computed.
module tb_exec_decode_unit;

`ifdef EXEC_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic [1:0]  reg_dst;
  logic        branch, mem_read, mem_write, alu_src, reg_write;
  logic [1:0]  mem_to_reg;
  logic [2:0]  alu_class;
  logic        imm_ext_sign;
  logic [4:0]  alu_sel;
  logic [31:0] alu_out;
  logic        zero;

  int testsRun = 0;
  int testsFailed = 0;

  exec_decode_unit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .opcode       (opcode),
    .func         (func),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .reg_dst      (reg_dst),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_class    (alu_class),
    .imm_ext_sign (imm_ext_sign),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  // Packed control word: reg_dst,branch,mem_read,mem_write,alu_src,reg_write,
  // mem_to_reg,alu_class,imm_ext_sign,alu_sel (18 bits).
  function automatic logic [17:0] ctl(input logic [1:0] rd, input logic br,
      input logic mr, input logic mw, input logic as, input logic rw,
      input logic [1:0] mtr, input logic [2:0] cls, input logic sx,
      input logic [4:0] sel);
    return {rd, br, mr, mw, as, rw, mtr, cls, sx, sel};
  endfunction

  function automatic logic [17:0] ctlObs();
    return {reg_dst, branch, mem_read, mem_write, alu_src, reg_write,
            mem_to_reg, alu_class, imm_ext_sign, alu_sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
      input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    in_valid = v;
    opcode   = op;
    func     = fn;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic chkAll(input string tag, input logic ov, input logic [17:0] c,
      input logic [31:0] res, input logic z);
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, ov});
    chk({tag, ".ctl"}, {14'h0, ctlObs()}, {14'h0, c});
    chk({tag, ".alu_out"}, alu_out, res);
    chk({tag, ".zero"}, {31'h0, zero}, {31'h0, z});
  endtask

  initial begin
    logic [31:0] expSrav, expSllv;
    logic        expSravZ;
    logic [4:0]  selSrav;
    expSrav  = SHIFT_EN ? 32'hF8000000 : 32'h0;
    expSravZ = SHIFT_EN ? 1'b0 : 1'b1;
    selSrav  = SHIFT_EN ? 5'd10 : 5'd31;
    expSllv  = SHIFT_EN ? 32'h00000010 : 32'h0;

    #12;
    chkAll("reset", 1'b0, 18'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // addi 3+4, then async reset between edges
    drive(1'b1, 6'b001000, 6'd0, 32'd3, 32'd4);
    chkAll("addi", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd0,1,5'd0), 32'd7, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chkAll("async_rst", 1'b0, 18'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 6'b100011, 6'd0, 32'h100, 32'h8);
    chkAll("lw", 1'b1, ctl(2'd0,0,1,0,1,1,2'd1,3'd0,1,5'd0), 32'h108, 1'b0);

    drive(1'b1, 6'b000000, 6'b100010, 32'd5, 32'd5);
    chkAll("sub", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd1), 32'h0, 1'b1);

    drive(1'b1, 6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1);
    chkAll("slt", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd6), 32'd1, 1'b0);

    drive(1'b1, 6'b000000, 6'b101011, 32'hFFFFFFFF, 32'd1);
    chkAll("sltu", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd7), 32'd0, 1'b1);

    drive(1'b1, 6'b000000, 6'b100001, 32'hFFFFFFFF, 32'd2);
    chkAll("addu_wrap", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd0), 32'd1, 1'b0);

    drive(1'b1, 6'b000000, 6'b100111, 32'hF0F0F0F0, 32'h0F0F0000);
    chkAll("nor", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd5), 32'h00000F0F, 1'b0);

    drive(1'b1, 6'b001101, 6'd0, 32'hF0, 32'h0F);
    chkAll("ori", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd4,0,5'd3), 32'hFF, 1'b0);

    drive(1'b1, 6'b001100, 6'd0, 32'hFF, 32'hF0);
    chkAll("andi", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd3,0,5'd2), 32'hF0, 1'b0);

    drive(1'b1, 6'b001110, 6'd0, 32'hFF, 32'h0F);
    chkAll("xori", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd5,0,5'd4), 32'hF0, 1'b0);

    drive(1'b1, 6'b001010, 6'd0, 32'hFFFFFFFE, 32'd3);
    chkAll("slti", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd6,1,5'd6), 32'd1, 1'b0);

    drive(1'b1, 6'b001111, 6'd0, 32'h0, 32'h1234);
    chkAll("lui", 1'b1, ctl(2'd0,0,0,0,1,1,2'd0,3'd7,0,5'd11), 32'h12340000, 1'b0);

    drive(1'b1, 6'b000011, 6'd0, 32'd1, 32'd2);
    chkAll("jal", 1'b1, ctl(2'd2,0,0,0,0,1,2'd2,3'd0,0,5'd0), 32'd3, 1'b0);

    drive(1'b1, 6'b111111, 6'd0, 32'd1, 32'd2);
    chkAll("unknown_op", 1'b1, ctl(2'd0,0,0,0,0,0,2'd0,3'd0,0,5'd0), 32'd3, 1'b0);

    drive(1'b1, 6'b000010, 6'd0, 32'd0, 32'd0);
    chkAll("j", 1'b1, 18'h0, 32'd0, 1'b1);

    drive(1'b1, 6'b000100, 6'd0, 32'd7, 32'd7);
    chkAll("beq", 1'b1, ctl(2'd0,1,0,0,0,0,2'd0,3'd1,1,5'd1), 32'd0, 1'b1);

    drive(1'b1, 6'b101011, 6'd0, 32'h200, 32'hFFFFFFFC);
    chkAll("sw", 1'b1, ctl(2'd0,0,0,1,1,0,2'd0,3'd0,1,5'd0), 32'h1FC, 1'b0);

    drive(1'b1, 6'b000000, 6'b001000, 32'd9, 32'd9);
    chkAll("bad_func", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,5'd31), 32'd0, 1'b1);

    drive(1'b1, 6'b000000, 6'b000100, 32'd4, 32'd1);
    chkAll("sllv", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,SHIFT_EN ? 5'd8 : 5'd31),
           expSllv, SHIFT_EN ? 1'b0 : 1'b1);

    drive(1'b1, 6'b000000, 6'b000111, 32'd4, 32'h80000000);
    chkAll("srav", 1'b1, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,selSrav), expSrav, expSravZ);

    // in_valid low: only out_valid drops, payload holds the srav capture
    drive(1'b0, 6'b100011, 6'd0, 32'h55, 32'h66);
    chkAll("hold", 1'b0, ctl(2'd1,0,0,0,0,1,2'd0,3'd2,0,selSrav), expSrav, expSravZ);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
